// File: rtl/aes_dec_pkg.sv
// Shared types and widths for the AES-256 decryption round datapath.
package aes_dec_pkg;

  localparam int AES_STATE_W = 128;
  localparam int AES_COL_W   = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_t;

  // Multiply by x in GF(2^8) modulo the AES polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/inv_mix_columns_seq_helper.sv
// Combinational InvMixColumns on one 32-bit column; byte 0 is rc[31:24].
module MixColumnHelper
  import aes_dec_pkg::*;
(
  input  logic [AES_COL_W-1:0] rc,
  output logic [AES_COL_W-1:0] mcl
);

  for (genvar j = 0; j < 4; j++) begin : g_byte
    logic [7:0] a, x2, x4, x8;
    logic [7:0] m9, m11, m13, m14;
    assign a   = rc[31-8*j -: 8];
    assign x2  = xtime(a);
    assign x4  = xtime(x2);
    assign x8  = xtime(x4);
    assign m9  = x8 ^ a;
    assign m11 = x8 ^ x2 ^ a;
    assign m13 = x8 ^ x4 ^ a;
    assign m14 = x8 ^ x4 ^ x2;
  end

  // Circulant matrix rows {14,11,13,9} rotated per output byte.
  assign mcl[31:24] = g_byte[0].m14 ^ g_byte[1].m11 ^ g_byte[2].m13 ^ g_byte[3].m9;
  assign mcl[23:16] = g_byte[0].m9  ^ g_byte[1].m14 ^ g_byte[2].m11 ^ g_byte[3].m13;
  assign mcl[15:8]  = g_byte[0].m13 ^ g_byte[1].m9  ^ g_byte[2].m14 ^ g_byte[3].m11;
  assign mcl[7:0]   = g_byte[0].m11 ^ g_byte[1].m13 ^ g_byte[2].m9  ^ g_byte[3].m14;

endmodule

// File: rtl/inv_mix_columns_seq.sv
// Iterative InvMixColumns: COLS_PER_CYCLE columns per RUN cycle, rewritten in place.
// Bypass requests go straight to DONE; the result is held until out_ready.
module inv_mix_columns_seq
  import aes_dec_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AES_STATE_W-1:0] in_state,
  input  logic                   in_bypass,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AES_STATE_W-1:0] out_state,
  output logic                   busy
);

  if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
    $error("COLS_PER_CYCLE must be 1, 2 or 4");
  end

  localparam logic [1:0] LAST_IDX = 2'(4 - COLS_PER_CYCLE);
  localparam logic [1:0] IDX_STEP = 2'(COLS_PER_CYCLE);

  fsm_t state, state_nxt;
  logic [1:0] col_idx;
  // work[3] is col0 ([127:96]), so column c lives at work[~c].
  logic [3:0][AES_COL_W-1:0] work;
  logic [1:0]           sel [COLS_PER_CYCLE];
  logic [AES_COL_W-1:0] mcl [COLS_PER_CYCLE];

  for (genvar k = 0; k < COLS_PER_CYCLE; k++) begin : g_col
    assign sel[k] = col_idx + 2'(k);
    MixColumnHelper u_helper (
      .rc  (work[~sel[k]]),
      .mcl (mcl[k])
    );
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (in_valid) state_nxt = in_bypass ? DONE : RUN;
      RUN:     if (col_idx == LAST_IDX) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      col_idx <= 2'd0;
      work    <= '0;
    end else begin
      state <= state_nxt;
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            work    <= in_state;
            col_idx <= 2'd0;
          end
        end
        RUN: begin
          for (int k = 0; k < COLS_PER_CYCLE; k++) begin
            work[~sel[k]] <= mcl[k];
          end
          col_idx <= col_idx + IDX_STEP;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign out_state = work;

endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// Directed and randomized checks of inv_mix_columns_seq at 1, 2 and 4 columns per cycle.
module tb_inv_mix_columns_seq;

  logic clk;
  logic rst;
  logic         in_valid  [3];
  logic         in_ready  [3];
  logic [127:0] in_state  [3];
  logic         in_bypass [3];
  logic         out_valid [3];
  logic         out_ready [3];
  logic [127:0] out_state [3];
  logic         busy      [3];

  int total = 0;
  int bad   = 0;

  localparam logic [127:0] FIPS_IN  = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] FIPS_OUT = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] BYP_IN   = 128'h00112233_44556677_8899aabb_ccddeeff;

  inv_mix_columns_seq #(.COLS_PER_CYCLE(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_state(in_state[0]), .in_bypass(in_bypass[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .out_state(out_state[0]), .busy(busy[0]));
  inv_mix_columns_seq #(.COLS_PER_CYCLE(2)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_state(in_state[1]), .in_bypass(in_bypass[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .out_state(out_state[1]), .busy(busy[1]));
  inv_mix_columns_seq #(.COLS_PER_CYCLE(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_state(in_state[2]), .in_bypass(in_bypass[2]), .out_valid(out_valid[2]),
    .out_ready(out_ready[2]), .out_state(out_state[2]), .busy(busy[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Golden GF(2^8) model built from shift-and-add multiplication.
  function automatic logic [7:0] xt(input logic [7:0] b);
    logic [7:0] s;
    s = b << 1;
    return b[7] ? (s ^ 8'h1b) : s;
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] b, input logic [3:0] c);
    logic [7:0] r, p;
    r = 8'h00;
    p = b;
    for (int j = 0; j < 4; j++) begin
      if (c[j]) r = r ^ p;
      p = xt(p);
    end
    return r;
  endfunction

  function automatic logic [31:0] inv_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {gm(a0,14) ^ gm(a1,11) ^ gm(a2,13) ^ gm(a3,9),
            gm(a0,9)  ^ gm(a1,14) ^ gm(a2,11) ^ gm(a3,13),
            gm(a0,13) ^ gm(a1,9)  ^ gm(a2,14) ^ gm(a3,11),
            gm(a0,11) ^ gm(a1,13) ^ gm(a2,9)  ^ gm(a3,14)};
  endfunction

  function automatic logic [127:0] inv_state(input logic [127:0] s);
    return {inv_col(s[127:96]), inv_col(s[95:64]), inv_col(s[63:32]), inv_col(s[31:0])};
  endfunction

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present a request at the current (post-edge) time; returns once it is accepted.
  task automatic issue(input int i, input logic [127:0] st, input logic byp);
    int guard;
    guard = 0;
    while (!in_ready[i] && guard < 40) begin
      @(posedge clk); #1;
      guard++;
    end
    in_state[i]  = st;
    in_bypass[i] = byp;
    in_valid[i]  = 1'b1;
    @(posedge clk); #1;
    in_valid[i]  = 1'b0;
    in_state[i]  = ~st;
    in_bypass[i] = ~byp;
  endtask

  // Edges counted from and including the accept edge until out_valid is seen.
  task automatic wait_out(input int i, output int lat);
    lat = 1;
    while (!out_valid[i] && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("out_valid_seen", 128'(out_valid[i]), 128'd1);
  endtask

  task automatic consume(input int i);
    out_ready[i] = 1'b1;
    @(posedge clk); #1;
    out_ready[i] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    logic [127:0] held, st, exp;
    int lat_exp [3];

    lat_exp[0] = 5; lat_exp[1] = 3; lat_exp[2] = 2;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid[i] = 1'b0; in_state[i] = '0; in_bypass[i] = 1'b0; out_ready[i] = 1'b0;
    end
    // Inputs active during reset must not be picked up.
    in_valid[0] = 1'b1; in_state[0] = FIPS_IN;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready",  128'(in_ready[0]),  128'd1);
    chk("rst_out_valid", 128'(out_valid[0]), 128'd0);
    chk("rst_busy",      128'(busy[0]),      128'd0);
    chk("rst_out_state", out_state[0],       128'd0);
    in_valid[0] = 1'b0;
    rst = 1'b0;

    // FIPS-197 column vector
    issue(0, FIPS_IN, 1'b0);
    chk("fips_busy", 128'(busy[0]), 128'd1);
    wait_out(0, lat);
    chk("fips_lat", 128'(lat), 128'd5);
    chk("fips_out", out_state[0], FIPS_OUT);
    consume(0);

    // Bypass, with out_ready already high before out_valid
    out_ready[0] = 1'b1;
    issue(0, BYP_IN, 1'b1);
    wait_out(0, lat);
    chk("byp_lat", 128'(lat), 128'd1);
    chk("byp_out", out_state[0], BYP_IN);
    @(posedge clk); #1;
    out_ready[0] = 1'b0;
    chk("byp_idle", 128'(in_ready[0]), 128'd1);

    // Backpressure: result held for 10 cycles while a new request waits
    issue(0, FIPS_IN, 1'b0);
    wait_out(0, lat);
    in_state[0] = BYP_IN;
    in_valid[0] = 1'b1;
    for (int c = 0; c < 10; c++) begin
      chk("bp_valid",    128'(out_valid[0]), 128'd1);
      chk("bp_state",    out_state[0],       FIPS_OUT);
      chk("bp_in_ready", 128'(in_ready[0]),  128'd0);
      @(posedge clk); #1;
    end
    in_valid[0] = 1'b0;
    consume(0);
    chk("bp_idle_ready", 128'(in_ready[0]), 128'd1);
    chk("bp_idle_busy",  128'(busy[0]),     128'd0);

    // Reset on the second RUN cycle
    issue(0, FIPS_IN, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_valid", 128'(out_valid[0]), 128'd0);
    chk("mid_rst_ready", 128'(in_ready[0]),  128'd1);
    chk("mid_rst_busy",  128'(busy[0]),      128'd0);
    issue(0, FIPS_IN, 1'b0);
    wait_out(0, lat);
    chk("post_rst_lat", 128'(lat), 128'd5);
    chk("post_rst_out", out_state[0], FIPS_OUT);
    consume(0);

    // Request held high while busy is accepted only after returning to IDLE
    issue(0, FIPS_IN, 1'b0);
    held = 128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0;
    in_state[0]  = held;
    in_bypass[0] = 1'b0;
    in_valid[0]  = 1'b1;
    wait_out(0, lat);
    chk("busy_in_lat", 128'(lat), 128'd5);
    chk("busy_in_out", out_state[0], FIPS_OUT);
    consume(0);
    chk("busy_in_idle", 128'(in_ready[0]), 128'd1);
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    chk("busy_in_acc", 128'(busy[0]), 128'd1);
    wait_out(0, lat);
    chk("held_lat", 128'(lat), 128'd5);
    chk("held_out", out_state[0], inv_state(held));
    consume(0);

    // Random sweep at 2 and 4 columns per cycle
    for (int i = 1; i < 3; i++) begin
      for (int n = 0; n < 1000; n++) begin
        st  = {$urandom, $urandom, $urandom, $urandom};
        exp = inv_state(st);
        issue(i, st, 1'b0);
        wait_out(i, lat);
        chk("sweep_lat", 128'(lat), 128'(lat_exp[i]));
        chk("sweep_out", out_state[i], exp);
        consume(i);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
